// File: rtl/cisr_row_decoder.sv
// -----------------------------------------------------------------------------
// cisr_row_decoder
//
// Purpose:
//   Row-ID decoder for a CISR-encoded sparse matrix feeding CHAN_NUM parallel
//   SpMV channels. Each channel tracks the row it is currently streaming
//   (cur_row) and how many nonzeros of that row are still to come (remaining).
//   When a channel runs out of nonzeros it pops the next row length from its
//   per-channel FIFO and is handed the next unassigned row ID from a shared
//   counter. Simultaneous requests get consecutive IDs in ascending channel
//   order.
//
// Optional feature:
//   CISR_ZERO_ROW_EN - when defined, every popped zero-length row produces a
//   one-cycle zr_valid pulse carrying its row ID. When undefined, zero-length
//   rows still consume an ID but zr_valid / zr_row_id are tied to 0.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   spmv_init      synchronous job restart (same effect as reset)
//   num_rows       total rows of the job (DIM_W+1 bits)
//   row_len_in     per-channel FIFO head, slice c = channel c (DATA_W each)
//   row_len_valid  per-channel FIFO non-empty
//   nz_adv         per-channel: one nonzero fetched this cycle
//   pop_len        combinational per-channel FIFO read enable
//   row_id_out     registered row ID of the nonzero fetched last cycle
//   zr_valid       registered zero-length-row pulse (feature only)
//   zr_row_id      row ID paired with zr_valid
//   done           registered: all rows assigned and fully consumed
//   err            sticky: nonzero fetched by a channel with no active row
// -----------------------------------------------------------------------------
module cisr_row_decoder #(
    parameter int CHAN_NUM = 16,
    parameter int DATA_W   = 32,
    parameter int DIM_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spmv_init,
    input  logic [DIM_W:0]             num_rows,
    input  logic [CHAN_NUM*DATA_W-1:0] row_len_in,
    input  logic [CHAN_NUM-1:0]        row_len_valid,
    input  logic [CHAN_NUM-1:0]        nz_adv,
    output logic [CHAN_NUM-1:0]        pop_len,
    output logic [CHAN_NUM*DIM_W-1:0]  row_id_out,
    output logic [CHAN_NUM-1:0]        zr_valid,
    output logic [CHAN_NUM*DIM_W-1:0]  zr_row_id,
    output logic                       done,
    output logic                       err
);

    // Reset and job restart are treated identically.
    logic clear;
    assign clear = !rst_n || spmv_init;

    logic [DIM_W:0]        next_row_q;
    logic [DIM_W:0]        next_row_d;
    logic [DIM_W:0]        avail;
    logic [CHAN_NUM-1:0]   active;
    logic [CHAN_NUM-1:0]   cand;
    logic                  err_q;
    logic                  err_d;
    logic                  done_q;
    logic                  done_d;

    // rank[c]: number of lower-index channels that want a row and have one
    // available. Only the first 'avail' candidates are served, so pops form
    // a prefix of the candidate list and rank[c] is also the ID offset.
    logic [DIM_W:0] rank [CHAN_NUM];
    // pcnt[c]: running popcount of pop_len below channel c.
    logic [DIM_W:0] pcnt [CHAN_NUM+1];

    // Rows still unassigned; guarded so a shrinking num_rows cannot wrap.
    assign avail = (next_row_q < num_rows) ? (num_rows - next_row_q) : '0;

    assign pcnt[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHAN_NUM; gi++) begin : g_chan
            logic [DATA_W-1:0] len;
            logic [DATA_W-1:0] rem_q;
            logic [DATA_W-1:0] rem_d;
            logic [DIM_W-1:0]  cur_row_q;
            logic [DIM_W-1:0]  cur_row_d;
            logic [DIM_W-1:0]  rid_q;
            logic [DIM_W-1:0]  rid_d;
            logic [DIM_W-1:0]  assign_id;
            logic              req;

            assign len       = row_len_in[gi*DATA_W +: DATA_W];
            assign active[gi] = (rem_q != '0);
            // A channel finishing its last nonzero this cycle asks for the
            // next row already, so it can start streaming without a bubble.
            assign req       = !active[gi] || ((rem_q == DATA_W'(1)) && nz_adv[gi]);
            assign cand[gi]  = req && row_len_valid[gi];

            if (gi == 0) begin : g_rank0
                assign rank[gi] = '0;
            end else begin : g_rankn
                assign rank[gi] = rank[gi-1] + {{DIM_W{1'b0}}, cand[gi-1]};
            end

            assign pop_len[gi]  = !clear && cand[gi] && (rank[gi] < avail);
            assign pcnt[gi+1]   = pcnt[gi] + {{DIM_W{1'b0}}, pop_len[gi]};
            assign assign_id    = next_row_q[DIM_W-1:0] + rank[gi][DIM_W-1:0];

            always_comb begin
                rem_d     = rem_q;
                cur_row_d = cur_row_q;
                rid_d     = rid_q;
                // Tag the fetched nonzero with the row it belongs to before a
                // same-cycle pop replaces cur_row.
                if (nz_adv[gi] && active[gi]) begin
                    rid_d = cur_row_q;
                    rem_d = rem_q - DATA_W'(1);
                end
                if (pop_len[gi]) begin
                    cur_row_d = assign_id;
                    rem_d     = len;
                end
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    rem_q     <= '0;
                    cur_row_q <= '0;
                    rid_q     <= '0;
                end else begin
                    rem_q     <= rem_d;
                    cur_row_q <= cur_row_d;
                    rid_q     <= rid_d;
                end
            end

            assign row_id_out[gi*DIM_W +: DIM_W] = rid_q;

`ifdef CISR_ZERO_ROW_EN
            logic             zr_valid_q;
            logic [DIM_W-1:0] zr_id_q;

            always_ff @(posedge clk) begin
                if (clear) begin
                    zr_valid_q <= 1'b0;
                    zr_id_q    <= '0;
                end else begin
                    zr_valid_q <= pop_len[gi] && (len == '0);
                    zr_id_q    <= (pop_len[gi] && (len == '0)) ? assign_id : '0;
                end
            end

            assign zr_valid[gi]                 = zr_valid_q;
            assign zr_row_id[gi*DIM_W +: DIM_W] = zr_id_q;
`else
            assign zr_valid[gi]                 = 1'b0;
            assign zr_row_id[gi*DIM_W +: DIM_W] = '0;
`endif
        end
    endgenerate

    assign next_row_d = next_row_q + pcnt[CHAN_NUM];
    // A nonzero reported by a channel with no open row is a protocol error.
    assign err_d      = err_q || |(nz_adv & ~active);
    assign done_d     = (next_row_q == num_rows) && (active == '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            next_row_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            next_row_q <= next_row_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign err  = err_q;
    assign done = done_q;

endmodule
